// File: rtl/uart_rx_core.sv
// UART receiver core: 8 data bits, LSB first, one stop bit, mid-bit sampling.
// Optional even parity bit before the stop bit when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_rx,
    input  logic       rst_rx,
    input  logic       rx_serial,
    output logic [7:0] data_rx,
    output logic       ready_rx,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic            line;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_d;
    logic            ready_d, ferr_d, perr_d;
    logic            par_bad;

    assign line = sync_q[1];
    assign busy = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    // Even parity: data bits plus parity bit must XOR to zero
    assign par_bad = ^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = CW'(cnt_q + 1'b1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_rx;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!line) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    bit_d   = 3'(bit_q + 3'd1);
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = line;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Return to IDLE at mid-stop so a following start edge is caught
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    ferr_d  = !line;
                    perr_d  = par_bad;
                    ready_d = line && !par_bad;
                    if (line && !par_bad) data_d = shift_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            sync_q     <= 2'b11;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_rx    <= '0;
            ready_rx   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], rx_serial};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_rx    <= data_d;
            ready_rx   <= ready_d;
            frame_err  <= ferr_d;
            parity_err <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: table of frames plus glitch,
// back-to-back, break and mid-frame reset sequences.
module tb_uart_rx_core;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT   = 171;
    localparam int FRAME = 176;
`else
    localparam int LAT   = 155;
    localparam int FRAME = 160;
`endif

    logic       clk_rx = 1'b0;
    logic       rst_rx = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] data_rx;
    logic       ready_rx, frame_err, parity_err, busy;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk_rx    (clk_rx),
        .rst_rx    (rst_rx),
        .rx_serial (rx_serial),
        .data_rx   (data_rx),
        .ready_rx  (ready_rx),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk_rx = ~clk_rx;

    int cyc = 0;
    int rdy_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    int rdy_cyc_q[$];
    logic [7:0] rdy_dat_q[$];
    int checks = 0, errors = 0;

    always @(posedge clk_rx) cyc <= cyc + 1;

    always @(negedge clk_rx) begin
        if (ready_rx) begin
            rdy_cnt <= rdy_cnt + 1;
            rdy_cyc_q.push_back(cyc);
            rdy_dat_q.push_back(data_rx);
        end
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        int         exp_rdy;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic pflip);
        rx_serial = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            wait_cyc(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_serial = (^d) ^ pflip;
        wait_cyc(CPB);
`else
        if (pflip) $display("note: parity flip ignored without parity");
`endif
        rx_serial = stop;
        wait_cyc(CPB);
        rx_serial = 1'b1;
    endtask

    initial begin
        int t0, r0, f0, p0, q0;
        logic [7:0] d0;

        vecs.push_back('{8'h4D, 1'b1, 1'b0, 1, 0, 0, 8'h4D});
        vecs.push_back('{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'hA5});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 1, 0, 0, 8'h81});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 0, 0, 8'h00});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 0, 0, 8'hFF});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h4D, 1'b1, 1'b1, 0, 0, 1, 8'hFF});
        vecs.push_back('{8'h4D, 1'b0, 1'b1, 0, 1, 1, 8'hFF});
        vecs.push_back('{8'h4D, 1'b1, 1'b0, 1, 0, 0, 8'h4D});
`endif

        wait_cyc(3);
        chk("rst data_rx", int'(data_rx), 0);
        chk("rst ready_rx", int'(ready_rx), 0);
        chk("rst frame_err", int'(frame_err), 0);
        chk("rst parity_err", int'(parity_err), 0);
        chk("rst busy", int'(busy), 0);
        rst_rx = 1'b0;
        wait_cyc(4);

        foreach (vecs[i]) begin
            r0 = rdy_cnt; f0 = ferr_cnt; p0 = perr_cnt; q0 = rdy_cyc_q.size();
            t0 = cyc;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].pflip);
            wait_cyc(2 * CPB);
            chk($sformatf("v%0d ready", i), rdy_cnt - r0, vecs[i].exp_rdy);
            chk($sformatf("v%0d ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            chk($sformatf("v%0d perr", i), perr_cnt - p0, vecs[i].exp_perr);
            chk($sformatf("v%0d data", i), int'(data_rx),
                int'(vecs[i].exp_data));
            if (vecs[i].exp_rdy == 1 && rdy_cyc_q.size() > q0)
                chk($sformatf("v%0d latency", i), rdy_cyc_q[q0] - t0, LAT);
        end

        // Back-to-back frames with no idle gap
        r0 = rdy_cnt; q0 = rdy_cyc_q.size();
        send_frame(8'h4D, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_cyc(2 * CPB);
        chk("b2b count", rdy_cnt - r0, 2);
        if (rdy_cyc_q.size() >= q0 + 2) begin
            chk("b2b first", int'(rdy_dat_q[q0]), 8'h4D);
            chk("b2b second", int'(rdy_dat_q[q0+1]), 8'hA5);
            chk("b2b spacing", rdy_cyc_q[q0+1] - rdy_cyc_q[q0], FRAME);
        end

        // 40 ns low glitch on idle line
        r0 = rdy_cnt; f0 = ferr_cnt; p0 = perr_cnt; d0 = data_rx;
        rx_serial = 1'b0;
        wait_cyc(4);
        rx_serial = 1'b1;
        wait_cyc(1);
        chk("glitch busy", int'(busy), 1);
        wait_cyc(20);
        chk("glitch idle", int'(busy), 0);
        chk("glitch pulses", (rdy_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        chk("glitch data", int'(data_rx), int'(d0));

        // Break: line held low
        r0 = rdy_cnt; f0 = ferr_cnt;
        rx_serial = 1'b0;
        wait_cyc(320);
`ifdef UART_RX_PARITY_EN
        chk("break ferr", ferr_cnt - f0, 1);
`else
        chk("break ferr", ferr_cnt - f0, 2);
`endif
        chk("break ready", rdy_cnt - r0, 0);
        chk("break busy", int'(busy), 1);
        #2 rst_rx = 1'b1;
        #1 chk("break rst busy", int'(busy), 0);
        rx_serial = 1'b1;
        wait_cyc(3);
        rst_rx = 1'b0;
        wait_cyc(4);

        // Good frame to load data, then reset during D4 of 0xFF
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_cyc(2 * CPB);
        chk("pre-rst data", int'(data_rx), 8'h5A);
        r0 = rdy_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        rx_serial = 1'b0;
        wait_cyc(CPB);
        rx_serial = 1'b1;
        wait_cyc(4 * CPB + CPB / 2);
        #2 rst_rx = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst data", int'(data_rx), 0);
        wait_cyc(3);
        rst_rx = 1'b0;
        wait_cyc(3 * CPB);
        chk("midrst pulses", (rdy_cnt - r0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_cyc(2 * CPB);
        chk("post-rst ready", rdy_cnt - r0, 1);
        chk("post-rst data", int'(data_rx), 8'h12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk_rx cycles per serial bit; even, >= 4.
REQ-002 clk_rx  input  1  receive clock; all state updates on its rising edge.
REQ-003 rst_rx  input  1  reset; asynchronous, active-high.
REQ-004 rx_serial  input  1  serial line; idle high; asynchronous to clk_rx.
REQ-005 data_rx  output  8  last correctly framed byte; held until the next good frame.
REQ-006 ready_rx  output  1  one-cycle pulse: data_rx was updated this cycle.
REQ-007 frame_err  output  1  one-cycle pulse: stop bit was sampled low.
REQ-008 parity_err  output  1  one-cycle pulse: parity mismatch (see REQ-030).
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 rx_serial SHALL pass through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronizer output.
REQ-011 FSM states SHALL be: IDLE, START, DATA, PARITY (only with the macro in REQ-029), STOP.
REQ-012 IDLE: line low -> START with the bit counter cleared; otherwise stay.
REQ-013 START: sample the line when the counter reaches CLKS_PER_BIT/2-1; low -> DATA with the counter cleared; high -> IDLE with no output pulse (glitch reject).
REQ-014 DATA: sample every CLKS_PER_BIT cycles; 8 samples, LSB first, shifted into an internal register; after bit 7 -> PARITY if enabled, else STOP.
REQ-015 PARITY: one sample CLKS_PER_BIT cycles after the previous one, then -> STOP.
REQ-016 STOP: sample CLKS_PER_BIT cycles after the previous one, then -> IDLE in the same cycle (no wait for the stop-bit end), so back-to-back frames are accepted.
REQ-017 Stop sample high and no parity error: data_rx <= shift register and ready_rx = 1 for exactly the next cycle.
REQ-018 Stop sample low: frame_err = 1 for one cycle; data_rx unchanged; ready_rx stays 0.
REQ-019 ready_rx, frame_err and parity_err SHALL be registered, and each SHALL pulse for exactly one cycle per frame.
REQ-020 Latency: the stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after START entry (+CLKS_PER_BIT with parity); pulses follow 1 cycle later.
REQ-021 Counter width SHALL be clog2(CLKS_PER_BIT); it SHALL wrap to 0 at each sample point.
REQ-022 Line held low continuously (break): frame_err pulses at STOP; IDLE then re-enters START immediately; no ready_rx.
REQ-023 Line edges between sample points SHALL NOT affect state; only sample points matter.

Reset
REQ-024 Asserting rst_rx SHALL immediately force IDLE, clear the counters and shift register, and set the synchronizer flops to 1.
REQ-025 Reset values: data_rx = 8'h00, ready_rx = 0, frame_err = 0, parity_err = 0, busy = 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; no pulse follows release.
REQ-027 After release, a frame whose start edge arrives at least 2 cycles later SHALL be received normally.
REQ-028 Line low at reset release SHALL be treated as a start edge (no reset-time qualification).

Configuration
REQ-029 Macro UART_RX_PARITY_EN: when defined, one even-parity bit is expected between D7 and the stop bit.
REQ-030 With the macro, a parity mismatch SHALL pulse parity_err in the same cycle as the stop-sample result and suppress ready_rx and the data_rx update; a frame error takes precedence, and frame_err and parity_err may pulse together.
REQ-031 Without the macro, the PARITY state does not exist, parity_err is tied 0, and the frame is 10 bits.

Verification (CLKS_PER_BIT=16, clk_rx period 10 ns)
REQ-032 Send 0x4D, 8N1, 160 ns/bit -> data_rx=0x4D, one ready_rx pulse 1 cycle after the stop sample, frame_err=0.
REQ-033 Send 0x4D then 0xA5 back-to-back, no idle gap -> two ready_rx pulses 160 cycles apart, data_rx=0x4D then 0xA5.
REQ-034 Low glitch of 40 ns on an idle line -> FSM returns to IDLE, no pulses, data_rx unchanged.
REQ-035 0x3C sent with stop bit forced low -> frame_err pulse, no ready_rx, data_rx keeps its prior value; line back high -> next 0x81 received OK.
REQ-036 Reset asserted during D4 of 0xFF -> busy=0 immediately, no pulse afterwards; following 0x12 received correctly.
REQ-037 With UART_RX_PARITY_EN: 0x4D with parity 0 -> ready_rx; with parity 1 -> parity_err pulse, no ready_rx.
